// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. One outstanding imem
// request; a one-entry skid catches a returning word while decode is stalled.
module fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            stall_d,
   input  logic            branch_taken_e,
   input  logic [XLEN-1:0] branch_target_e,
   output logic [31:0]     instr_d,
   output logic [XLEN-1:0] pc_d,
   output logic [XLEN-1:0] pcplus_d,
   output logic            valid_d
);

   // Handshakes: a request transfers on a cycle with imem_req & imem_ready;
   // exactly one imem_rvalid follows each transfer, on a later cycle.
   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   state_t          state, state_next;
   logic [XLEN-1:0] pc, pc_next;
   logic [XLEN-1:0] fetch_pc;
   logic            drop, drop_next;
   logic [31:0]     skid_instr;
   logic [XLEN-1:0] skid_pc;
   logic            handshake;
   logic            load_mem, load_skid, skid_load;

   assign imem_addr = pc;
   assign handshake = (state == REQ) && imem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      drop_next  = drop;
      imem_req   = 1'b0;
      load_mem   = 1'b0;
      load_skid  = 1'b0;
      skid_load  = 1'b0;
      case (state)
         IDLE: state_next = REQ;
         REQ: begin
            imem_req = 1'b1;
            if (handshake) begin
               state_next = WAIT;
               pc_next    = pc + STEP;
               if (branch_taken_e) drop_next = 1'b1;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               // A word arriving with drop set or alongside a branch is stale.
               state_next = REQ;
               drop_next  = 1'b0;
               if (!drop && !branch_taken_e) begin
                  if (!valid_d || !stall_d) begin
                     load_mem = 1'b1;
                  end else begin
                     skid_load  = 1'b1;
                     state_next = HOLD;
                  end
               end
            end else if (branch_taken_e) begin
               drop_next = 1'b1;
            end
         end
         HOLD: begin
            if (branch_taken_e) begin
               state_next = REQ;
            end else if (!stall_d) begin
               load_skid  = 1'b1;
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
      if (branch_taken_e) pc_next = branch_target_e;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= RESET_PC;
         fetch_pc   <= '0;
         drop       <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else begin
         pc   <= pc_next;
         drop <= drop_next;
         if (handshake) fetch_pc <= pc;
         if (skid_load) begin
            skid_instr <= imem_rdata;
            skid_pc    <= fetch_pc;
         end
      end
   end

   // IF/ID register: flush beats stall, stall holds everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_d  <= '0;
         pc_d     <= '0;
         pcplus_d <= '0;
         valid_d  <= 1'b0;
      end else if (branch_taken_e) begin
         instr_d <= '0;
         valid_d <= 1'b0;
      end else if (load_mem) begin
         instr_d  <= imem_rdata;
         pc_d     <= fetch_pc;
         pcplus_d <= fetch_pc + STEP;
         valid_d  <= 1'b1;
      end else if (load_skid) begin
         instr_d  <= skid_instr;
         pc_d     <= skid_pc;
         pcplus_d <= skid_pc + STEP;
         valid_d  <= 1'b1;
      end else if (!stall_d) begin
         instr_d <= '0;
         valid_d <= 1'b0;
      end
   end

endmodule
